// File: rtl/sram_bus_arbiter_if.sv
// SRAM req/addr_ok/data_ok bus: one instance per master port and one toward the slave.
interface sram_bus_arbiter_if #(
  parameter int BUS_W  = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic [BUS_W-1:0]  addr;
  logic [DATA_W-1:0] wdata;
  logic [MASK_W-1:0] wem;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, size, addr, wdata, wem, input addr_ok, data_ok, rdata);
  modport slave  (input req, we, size, addr, wdata, wem, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_bus_arbiter.sv
// Two-master round-robin arbiter in front of the SRAM slave; a tag FIFO of grant ids
// steers each in-order completion back to the master that issued it.
module sram_bus_arbiter #(
  parameter int BUS_W   = 32,
  parameter int DATA_W  = 32,
  parameter int MASK_W  = 4,
  parameter int MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_bus_arbiter_if.slave  m0,
  sram_bus_arbiter_if.slave  m1,
  sram_bus_arbiter_if.master s
);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUT - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [MAX_OUT-1:0] tag_q, tag_d;
  logic               last_grant_q, last_grant_d;

  logic              grant, can_issue, issue, accept, pop, pop_tag;
  logic              we_g;
  logic [1:0]        size_g;
  logic [BUS_W-1:0]  addr_g;
  logic [DATA_W-1:0] wdata_g;
  logic [MASK_W-1:0] wem_g;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    // Tie goes to whoever did not win last; a lone requester always wins.
    grant     = (m0.req & m1.req) ? ~last_grant_q : m1.req;
    can_issue = (cnt_q < CNT_MAX) | s.data_ok;
    issue     = rst_n & (m0.req | m1.req) & can_issue;
    accept    = issue & s.addr_ok;
    pop       = rst_n & s.data_ok & (cnt_q != '0);
    pop_tag   = tag_q[rd_ptr_q];

    we_g    = grant ? m1.we    : m0.we;
    size_g  = grant ? m1.size  : m0.size;
    addr_g  = grant ? m1.addr  : m0.addr;
    wdata_g = grant ? m1.wdata : m0.wdata;
    wem_g   = grant ? m1.wem   : m0.wem;

    s.req   = issue;
    s.we    = issue & we_g;
    s.size  = issue ? size_g  : '0;
    s.addr  = issue ? addr_g  : '0;
    s.wdata = issue ? wdata_g : '0;
    s.wem   = issue ? wem_g   : '0;

    m0.addr_ok = accept & ~grant;
    m1.addr_ok = accept & grant;
    m0.data_ok = pop & ~pop_tag;
    m1.data_ok = pop & pop_tag;
    m0.rdata   = (pop & ~pop_tag) ? s.rdata : '0;
    m1.rdata   = (pop & pop_tag)  ? s.rdata : '0;
  end

  always_comb begin
    cnt_d        = cnt_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    tag_d        = tag_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      tag_d[wr_ptr_q] = grant;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
      last_grant_d    = grant;
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      tag_q        <= '0;
      last_grant_q <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      tag_q        <= tag_d;
      last_grant_q <= last_grant_d;
    end
  end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Randomized bench for sram_bus_arbiter: behavioural slave stub plus an outstanding-queue
// reference model, with directed scenarios for arbitration, stalls, spurious pulses and reset.
module tb_sram_bus_arbiter;
  localparam int BUS_W = 32, DATA_W = 32, MASK_W = 4, MAX_OUT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_bus_arbiter_if #(.BUS_W(BUS_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) m0_if ();
  sram_bus_arbiter_if #(.BUS_W(BUS_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) m1_if ();
  sram_bus_arbiter_if #(.BUS_W(BUS_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) s_if ();

  sram_bus_arbiter #(.BUS_W(BUS_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n), .m0(m0_if), .m1(m1_if), .s(s_if)
  );

  typedef struct { logic vld; logic we; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wem; } mreq_t;
  typedef struct { int id; logic [31:0] rdata; } exp_t;
  typedef struct { int ready; logic [31:0] rdata; } slv_t;

  mreq_t       pend [2];
  exp_t        mq [$];
  slv_t        sq [$];
  int          glog [$];
  int          acyc [$];
  int          dcyc [$];
  logic [31:0] mem [int];
  logic [31:0] last_rd [2];
  logic [3:0]  last_wem;
  int          dok_cnt [2];
  int          mlast, cyc, lat, aok_pct, spur_pct, gen_pct;
  logic        auto_en [2];
  logic        spur_force;
  int          checks, errors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    int k;
    k = int'(a[31:2]);
    return mem.exists(k) ? mem[k] : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic wr_mem(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] w;
    w = rd_mem(a);
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    mem[int'(a[31:2])] = w;
  endtask

  function automatic mreq_t rnd_req();
    mreq_t r;
    r.vld   = 1'b1;
    r.we    = 1'($urandom_range(0, 1));
    r.size  = 2'd2;
    r.addr  = $urandom_range(0, 63) << 2;
    r.wdata = $urandom;
    r.wem   = 4'($urandom_range(0, 15));
    return r;
  endfunction

  function automatic mreq_t mk_req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    mreq_t r;
    r.vld = 1'b1; r.we = we; r.size = 2'd2; r.addr = a; r.wdata = d; r.wem = m;
    return r;
  endfunction

  // One clock: drive at start, check at negedge, advance models at posedge.
  task automatic cycle();
    logic [1:0]  r;
    int          g;
    logic        ei, ea, ep, d0, d1, sdr, s_acc, aok0, aok1, c_we;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_wem;
    exp_t        e;
    slv_t        se;
    for (int n = 0; n < 2; n++)
      if (auto_en[n] && !pend[n].vld && $urandom_range(0, 99) < gen_pct) pend[n] = rnd_req();
    m0_if.req = pend[0].vld; m0_if.we = pend[0].we; m0_if.size = pend[0].size;
    m0_if.addr = pend[0].addr; m0_if.wdata = pend[0].wdata; m0_if.wem = pend[0].wem;
    m1_if.req = pend[1].vld; m1_if.we = pend[1].we; m1_if.size = pend[1].size;
    m1_if.addr = pend[1].addr; m1_if.wdata = pend[1].wdata; m1_if.wem = pend[1].wem;
    sdr = 1'b0;
    if (sq.size() != 0 && sq[0].ready <= cyc) begin
      s_if.data_ok = 1'b1; s_if.rdata = sq[0].rdata; sdr = 1'b1;
    end else if (spur_force || (sq.size() == 0 && $urandom_range(0, 99) < spur_pct)) begin
      s_if.data_ok = 1'b1; s_if.rdata = $urandom;
    end else begin
      s_if.data_ok = 1'b0; s_if.rdata = $urandom;
    end
    spur_force = 1'b0;
    s_if.addr_ok = ($urandom_range(0, 99) < aok_pct);

    @(negedge clk);
    r  = {pend[1].vld, pend[0].vld};
    g  = (r == 2'b11) ? 1 - mlast : int'(r[1]);
    ei = rst_n && (r != 2'b00) && (mq.size() < MAX_OUT || s_if.data_ok);
    ea = ei && s_if.addr_ok;
    ep = rst_n && s_if.data_ok && (mq.size() != 0);
    chk("s_req", s_if.req, ei);
    if (ei) begin
      chk("s_addr", s_if.addr, pend[g].addr);
      chk("s_we", s_if.we, pend[g].we);
      chk("s_wdata", s_if.wdata, pend[g].wdata);
      chk("s_wem", s_if.wem, pend[g].wem);
      chk("s_size", s_if.size, pend[g].size);
    end else begin
      chk("s_addr_idle", s_if.addr, 32'h0);
    end
    chk("m0_addr_ok", m0_if.addr_ok, ea && g == 0);
    chk("m1_addr_ok", m1_if.addr_ok, ea && g == 1);
    d0 = ep && mq[0].id == 0;
    d1 = ep && mq[0].id == 1;
    chk("m0_data_ok", m0_if.data_ok, d0);
    chk("m1_data_ok", m1_if.data_ok, d1);
    chk("m0_rdata", m0_if.rdata, d0 ? mq[0].rdata : 32'h0);
    chk("m1_rdata", m1_if.rdata, d1 ? mq[0].rdata : 32'h0);
    aok0 = m0_if.addr_ok; aok1 = m1_if.addr_ok;
    if (aok0) begin glog.push_back(0); acyc.push_back(cyc); end
    if (aok1) begin glog.push_back(1); acyc.push_back(cyc); end
    if (m0_if.data_ok) begin dok_cnt[0]++; last_rd[0] = m0_if.rdata; dcyc.push_back(cyc); end
    if (m1_if.data_ok) begin dok_cnt[1]++; last_rd[1] = m1_if.rdata; dcyc.push_back(cyc); end
    s_acc = s_if.req && s_if.addr_ok;
    c_we = s_if.we; c_addr = s_if.addr; c_wdata = s_if.wdata; c_wem = s_if.wem;

    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      mq.delete();
      mlast = 1;
    end else begin
      if (ep) void'(mq.pop_front());
      if (ea) begin
        e.id = g;
        e.rdata = pend[g].we ? 32'h0 : rd_mem(pend[g].addr);
        mq.push_back(e);
        mlast = g;
      end
    end
    if (sdr) void'(sq.pop_front());
    if (s_acc) begin
      se.ready = cyc - 1 + lat;
      se.rdata = c_we ? 32'h0 : rd_mem(c_addr);
      sq.push_back(se);
      if (c_we) begin wr_mem(c_addr, c_wdata, c_wem); last_wem = c_wem; end
    end
    if (aok0) pend[0].vld = 1'b0;
    if (aok1) pend[1].vld = 1'b0;
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((pend[0].vld || pend[1].vld || mq.size() != 0 || sq.size() != 0) && n < 100) begin
      cycle(); n++;
    end
    if (n >= 100) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_acc(input int target);
    int n;
    n = 0;
    while (acyc.size() < target && n < 50) begin cycle(); n++; end
    if (acyc.size() < target) chk("acc_timeout", acyc.size(), target);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int rc, d, gbits;
    checks = 0; errors = 0; cyc = 0; mlast = 1; lat = 1;
    aok_pct = 100; spur_pct = 0; gen_pct = 0; spur_force = 1'b0;
    auto_en[0] = 1'b0; auto_en[1] = 1'b0;
    dok_cnt[0] = 0; dok_cnt[1] = 0;
    last_rd[0] = '0; last_rd[1] = '0; last_wem = '0;
    pend[0] = '{default: '0}; pend[1] = '{default: '0};
    mem[int'(32'h100 >> 2)] = 32'h1234_5678;
    mem[int'(32'h40 >> 2)]  = 32'h1111_2222;

    // Reset: a request during reset must not reach the slave.
    pend[0] = mk_req(1'b0, 32'h100, 32'h0, 4'h0);
    cycle(); cycle();
    chk("rst_no_accept", acyc.size(), 0);
    pend[0].vld = 1'b0;
    rst_n = 1'b1;
    cycle();

    // Single read from m0: accepted same cycle, data one cycle later.
    acyc.delete(); dcyc.delete();
    pend[0] = mk_req(1'b0, 32'h100, 32'h0, 4'h0);
    rc = cyc;
    wait_idle();
    chk("t1_acc_cycle", acyc[0], rc);
    chk("t1_lat", dcyc[0] - acyc[0], 1);
    chk("t1_rdata", last_rd[0], 32'h1234_5678);

    // Both masters request every cycle: strict alternation starting with m0.
    do_reset();
    glog.delete(); acyc.delete();
    d = dok_cnt[0] + dok_cnt[1];
    gen_pct = 100; auto_en[0] = 1'b1; auto_en[1] = 1'b1;
    wait_acc(6);
    auto_en[0] = 1'b0; auto_en[1] = 1'b0;
    gbits = 0;
    for (int i = 0; i < 6; i++) gbits |= glog[i] << i;
    chk("t2_grant_seq", gbits, 6'b101010);
    chk("t2_back2back", acyc[5] - acyc[0], 5);
    wait_idle();
    chk("t2_dok_total", dok_cnt[0] + dok_cnt[1] - d, glog.size());

    // m1 partial write then m0 read of the same word.
    pend[1] = mk_req(1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011);
    wait_idle();
    chk("t3_wem", last_wem, 4'b0011);
    pend[0] = mk_req(1'b0, 32'h40, 32'h0, 4'h0);
    wait_idle();
    chk("t3_rdata", last_rd[0], 32'h1111_BEEF);

    // Slow slave: third request waits for the first completion.
    lat = 3;
    acyc.delete(); dcyc.delete();
    gen_pct = 100; auto_en[0] = 1'b1; auto_en[1] = 1'b1;
    wait_acc(3);
    auto_en[0] = 1'b0; auto_en[1] = 1'b0;
    wait_idle();
    chk("t4_second", acyc[1] - acyc[0], 1);
    chk("t4_first_dok", dcyc[0] - acyc[0], 3);
    chk("t4_third_held", acyc[2] - acyc[0], 3);

    // Spurious completion with nothing outstanding.
    lat = 1;
    d = dok_cnt[0] + dok_cnt[1];
    spur_force = 1'b1;
    cycle();
    chk("t5_spur_dropped", dok_cnt[0] + dok_cnt[1] - d, 0);
    acyc.delete(); dcyc.delete();
    pend[0] = mk_req(1'b0, 32'h100, 32'h0, 4'h0);
    rc = cyc;
    wait_idle();
    chk("t5_acc_cycle", acyc[0], rc);
    chk("t5_lat", dcyc[0] - acyc[0], 1);

    // Reset with two outstanding: late completions are dropped.
    lat = 3;
    acyc.delete();
    pend[0] = mk_req(1'b0, 32'h100, 32'h0, 4'h0);
    pend[1] = mk_req(1'b0, 32'h40, 32'h0, 4'h0);
    wait_acc(2);
    do_reset();
    d = dok_cnt[0] + dok_cnt[1];
    wait_idle();
    chk("t6_dropped", dok_cnt[0] + dok_cnt[1] - d, 0);
    lat = 1;
    acyc.delete(); dcyc.delete();
    pend[1] = mk_req(1'b0, 32'h100, 32'h0, 4'h0);
    wait_idle();
    chk("t6_after_lat", dcyc[0] - acyc[0], 1);
    chk("t6_after_rdata", last_rd[1], 32'h1234_5678);

    // Random traffic with back-pressure, variable latency and spurious pulses.
    aok_pct = 75; spur_pct = 10; gen_pct = 50;
    auto_en[0] = 1'b1; auto_en[1] = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 3);
      cycle();
    end
    auto_en[0] = 1'b0; auto_en[1] = 1'b0;
    aok_pct = 100; spur_pct = 0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
